// File: rtl/drive_scheduler.sv
// Motion sequencer for the line-following car: debounces the tracker steering state, sequences
// drive modes (including lost-line search and halt) and ramps per-wheel PWM duty and direction.
module drive_scheduler #(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned SPEED_FAST    = 200,
  parameter int unsigned SPEED_SLOW    = 100,
  parameter int unsigned RAMP_STEP     = 8,
  parameter int unsigned RAMP_DIV      = 16,
  parameter int unsigned SEARCH_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] track_state,
  output logic [7:0] left_duty,
  output logic [7:0] right_duty,
  output logic       left_dir,
  output logic       right_dir,
  output logic [2:0] mode,
  output logic       lost
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStraight = 3'd1,
    StLeft     = 3'd2,
    StRight    = 3'd3,
    StSearch   = 3'd4,
    StHalt     = 3'd5
  } state_e;

  localparam logic [3:0]  DebN       = 4'(DEBOUNCE);
  localparam logic [7:0]  Fast       = 8'(SPEED_FAST);
  localparam logic [7:0]  Slow       = 8'(SPEED_SLOW);
  localparam logic [8:0]  Step       = 9'(RAMP_STEP);
  localparam int unsigned DivW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(RAMP_DIV - 1);
  localparam logic [15:0] SearchLoad = 16'(SEARCH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      cand_q, cand_d, filt_q, filt_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     srch_q, srch_d;
  logic            last_turn_q, last_turn_d;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [7:0]      l_duty_q, l_duty_d, r_duty_q, r_duty_d;
  logic            l_dir_q, l_dir_d, r_dir_q, r_dir_d;
  logic [7:0]      l_tgt, r_tgt;
  logic            l_tdir, r_tdir;

  function automatic state_e drive_of(input logic [1:0] f);
    case (f)
      2'b10:   drive_of = StStraight;
      2'b00:   drive_of = StLeft;
      2'b01:   drive_of = StRight;
      default: drive_of = StIdle;
    endcase
  endfunction

  // Returns {dir, duty}; a pending direction flip first ramps to zero, then flips on its own tick.
  function automatic logic [8:0] ramp(input logic [7:0] tgt, input logic tdir,
                                      input logic [7:0] duty, input logic dir);
    logic [8:0] d9, t9;
    d9   = {1'b0, duty};
    t9   = {1'b0, tgt};
    ramp = {dir, duty};
    if (tdir != dir) begin
      if (duty == 8'd0)   ramp = {tdir, 8'd0};
      else if (d9 > Step) ramp = {dir, 8'(d9 - Step)};
      else                ramp = {dir, 8'd0};
    end else if (d9 < t9) begin
      if (d9 + Step >= t9) ramp = {dir, tgt};
      else                 ramp = {dir, 8'(d9 + Step)};
    end else if (d9 > t9) begin
      if (d9 - t9 <= Step) ramp = {dir, tgt};
      else                 ramp = {dir, 8'(d9 - Step)};
    end
  endfunction

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (track_state != cand_q) begin
      cand_d = track_state;
      cnt_d  = 4'd1;
    end else if (cnt_q != DebN) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_d == DebN) filt_d = cand_d;
  end

  always_comb begin
    state_d = state_q;
    srch_d  = srch_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (filt_q != 2'b11) state_d = drive_of(filt_q);
        StStraight, StLeft, StRight: begin
          if (filt_q == 2'b11) begin
            state_d = StSearch;
            srch_d  = SearchLoad;
          end else begin
            state_d = drive_of(filt_q);
          end
        end
        StSearch: begin
          if (filt_q != 2'b11)     state_d = drive_of(filt_q);
          else if (srch_q == '0)   state_d = StHalt;
          else                     srch_d  = srch_q - 16'd1;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    last_turn_d = last_turn_q;
    if (state_d == StLeft && state_q != StLeft)   last_turn_d = 1'b0;
    if (state_d == StRight && state_q != StRight) last_turn_d = 1'b1;
  end

  always_comb begin
    l_tgt  = 8'd0;
    r_tgt  = 8'd0;
    l_tdir = 1'b1;
    r_tdir = 1'b1;
    case (state_q)
      StStraight: begin l_tgt = Fast; r_tgt = Fast; end
      StLeft:     begin l_tgt = Slow; r_tgt = Fast; end
      StRight:    begin l_tgt = Fast; r_tgt = Slow; end
      StSearch: begin
        l_tgt  = Slow;
        r_tgt  = Slow;
        l_tdir = last_turn_q;
        r_tdir = ~last_turn_q;
      end
      default: ;
    endcase
  end

  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    {l_dir_d, l_duty_d} = {l_dir_q, l_duty_q};
    {r_dir_d, r_duty_d} = {r_dir_q, r_duty_q};
    if (tick) begin
      {l_dir_d, l_duty_d} = ramp(l_tgt, l_tdir, l_duty_q, l_dir_q);
      {r_dir_d, r_duty_d} = ramp(r_tgt, r_tdir, r_duty_q, r_dir_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cand_q      <= 2'b11;
      filt_q      <= 2'b11;
      cnt_q       <= 4'd0;
      srch_q      <= 16'd0;
      last_turn_q <= 1'b0;
      div_q       <= '0;
      l_duty_q    <= 8'd0;
      r_duty_q    <= 8'd0;
      l_dir_q     <= 1'b1;
      r_dir_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      srch_q      <= srch_d;
      last_turn_q <= last_turn_d;
      div_q       <= div_d;
      l_duty_q    <= l_duty_d;
      r_duty_q    <= r_duty_d;
      l_dir_q     <= l_dir_d;
      r_dir_q     <= r_dir_d;
    end
  end

  assign left_duty  = l_duty_q;
  assign right_duty = r_duty_q;
  assign left_dir   = l_dir_q;
  assign right_dir  = r_dir_q;
  assign mode       = state_q;
  assign lost       = (state_q == StHalt);

endmodule

// File: tb/tb_drive_scheduler.sv
// Bench for drive_scheduler: directed scenarios plus random steering, all outputs checked every
// cycle against a behavioural model built from sample history and integer duty arithmetic.
module tb_drive_scheduler;

  localparam int DEB   = 4;
  localparam int FAST  = 200;
  localparam int SLOW  = 100;
  localparam int STEP  = 8;
  localparam int DIV   = 16;
  localparam int SRCH  = 1000;

  localparam int M_IDLE = 0, M_STR = 1, M_LEFT = 2, M_RIGHT = 3, M_SRCH = 4, M_HALT = 5;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] track_state;
  logic [7:0] left_duty, right_duty;
  logic       left_dir, right_dir;
  logic [2:0] mode;
  logic       lost;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int hist[$];
  int m_filt, m_mode, m_last, m_left_cycles, m_edge;
  int m_ld, m_rd, m_ldir, m_rdir;

  drive_scheduler #(
    .DEBOUNCE     (DEB),
    .SPEED_FAST   (FAST),
    .SPEED_SLOW   (SLOW),
    .RAMP_STEP    (STEP),
    .RAMP_DIV     (DIV),
    .SEARCH_CYCLES(SRCH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .track_state(track_state),
    .left_duty  (left_duty),
    .right_duty (right_duty),
    .left_dir   (left_dir),
    .right_dir  (right_dir),
    .mode       (mode),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int drive_mode(input int f);
    if (f == 2) return M_STR;
    if (f == 0) return M_LEFT;
    return M_RIGHT;
  endfunction

  task automatic wheel(input int tgt, input int tdir, input int d, input int r,
                       output int nd, output int nr);
    nr = r;
    if (tdir != r) begin
      if (d == 0) nr = tdir;
      nd = (d > STEP) ? d - STEP : 0;
    end else if (d < tgt) begin
      nd = (d + STEP < tgt) ? d + STEP : tgt;
    end else begin
      nd = (d - STEP > tgt) ? d - STEP : tgt;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int nf, nm, lt, rt, ltd, rtd, nd, nr;
    bit same;
    if (reset) begin
      hist.delete();
      m_filt = 3; m_mode = M_IDLE; m_last = 0; m_left_cycles = 0; m_edge = 0;
      m_ld = 0; m_rd = 0; m_ldir = 1; m_rdir = 1;
      return;
    end
    hist.push_back(int'(track_state));
    if (hist.size() > DEB) void'(hist.pop_front());
    nf = m_filt;
    same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
    if (same) nf = hist[0];

    nm = m_mode;
    if (!enable) nm = M_IDLE;
    else if (m_mode == M_IDLE) begin
      if (m_filt != 3) nm = drive_mode(m_filt);
    end else if (m_mode >= M_STR && m_mode <= M_RIGHT) begin
      if (m_filt == 3) begin
        nm = M_SRCH;
        m_left_cycles = SRCH - 1;
      end else nm = drive_mode(m_filt);
    end else if (m_mode == M_SRCH) begin
      if (m_filt != 3) nm = drive_mode(m_filt);
      else if (m_left_cycles == 0) nm = M_HALT;
      else m_left_cycles--;
    end

    lt = 0; rt = 0; ltd = 1; rtd = 1;
    if (m_mode == M_STR)   begin lt = FAST; rt = FAST; end
    if (m_mode == M_LEFT)  begin lt = SLOW; rt = FAST; end
    if (m_mode == M_RIGHT) begin lt = FAST; rt = SLOW; end
    if (m_mode == M_SRCH)  begin lt = SLOW; rt = SLOW; ltd = m_last; rtd = 1 - m_last; end
    if (m_edge % DIV == DIV - 1) begin
      wheel(lt, ltd, m_ld, m_ldir, nd, nr); m_ld = nd; m_ldir = nr;
      wheel(rt, rtd, m_rd, m_rdir, nd, nr); m_rd = nd; m_rdir = nr;
    end

    if (nm == M_LEFT && m_mode != M_LEFT)   m_last = 0;
    if (nm == M_RIGHT && m_mode != M_RIGHT) m_last = 1;
    m_mode = nm;
    m_filt = nf;
    m_edge++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("left_duty",  16'(left_duty),  16'(m_ld));
    check("right_duty", 16'(right_duty), 16'(m_rd));
    check("left_dir",   16'(left_dir),   16'(m_ldir));
    check("right_dir",  16'(right_dir),  16'(m_rdir));
    check("mode",       16'(mode),       16'(m_mode));
    check("lost",       16'(lost),       16'(m_mode == M_HALT));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int len;
    reset = 1'b1; enable = 1'b1; track_state = 2'b10;
    run(3);
    check("reset_mode", 16'(mode), 16'd0);
    check("reset_dir",  16'({left_dir, right_dir}), 16'd3);
    reset = 1'b0;

    // Straight from rest with a short glitch that must be ignored
    run(8);
    check("straight_mode", 16'(mode), 16'(M_STR));
    track_state = 2'b00; run(3);
    track_state = 2'b10; run(3);
    check("glitch_ignored", 16'(mode), 16'(M_STR));
    run(420);
    check("straight_full", 16'(left_duty), 16'(FAST));

    track_state = 2'b00; run(400);
    check("left_inner", 16'(left_duty), 16'(SLOW));
    check("left_outer", 16'(right_duty), 16'(FAST));

    // Line lost: search then halt
    track_state = 2'b11; run(300);
    check("search_mode", 16'(mode), 16'(M_SRCH));
    check("search_rev",  16'(left_dir), 16'd0);
    run(800);
    check("halt_lost", 16'(lost), 16'd1);
    run(500);
    check("halt_stopped", 16'(left_duty), 16'd0);

    enable = 1'b0; run(1);
    check("disable_idle", 16'(mode), 16'(M_IDLE));
    check("disable_lost", 16'(lost), 16'd0);
    enable = 1'b1; track_state = 2'b10; run(5);
    check("reenable_str", 16'(mode), 16'(M_STR));
    run(100);
    reset = 1'b1; run(1);
    check("reset_midramp", 16'(left_duty), 16'd0);
    reset = 1'b0;

    // Reacquire during search
    track_state = 2'b00; run(400);
    track_state = 2'b11; run(200);
    track_state = 2'b01; run(700);
    check("reacq_mode",  16'(mode), 16'(M_RIGHT));
    check("reacq_left",  16'(left_duty), 16'(FAST));
    check("reacq_right", 16'(right_duty), 16'(SLOW));

    // Random steering, enable drops and resets
    for (int s = 0; s < 300; s++) begin
      track_state = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 15) != 0);
      reset = ($urandom_range(0, 63) == 0);
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(100, 1200) : $urandom_range(1, 12);
      if (reset) len = 1;
      run(len);
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
